// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Mode encoding shared by the pipelined ALU, its bus and the bench.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_PASS = 2'b01,
        ALU_ACC  = 2'b10,
        ALU_SUB  = 2'b11
    } alu_mode_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_if
// Brief    : Operand/result streaming bus; slave = ALU side, master = source/sink.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] var_1;
    logic [WIDTH-1:0] var_2;
    alu_mode_e        mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output in_valid, var_1, var_2, mode, acc_clr, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, var_1, var_2, mode, acc_clr, out_ready,
        output in_ready, out_valid, result, overflow
    );

endinterface : alu_pipe_if
`default_nettype wire

// File: rtl/alu_sat_addsub.sv
`default_nettype none
// ============================================================================
// Module   : alu_sat_addsub
// Brief    : Signed add/sub with overflow detect and optional saturation.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sat_addsub #(
    parameter int WIDTH    = 5,
    parameter bit SATURATE = 1'b1
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             sub,
    output logic      [WIDTH-1:0] res,
    output logic                  ovf,
    output logic      [WIDTH:0]   full
);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;

    assign w_a_ext = {a[WIDTH-1], a};
    assign w_b_ext = {b[WIDTH-1], b};
    assign full    = sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
    // The extra sign bit disagrees with the result MSB exactly on signed overflow.
    assign ovf     = full[WIDTH] ^ full[WIDTH-1];

    generate
        if (SATURATE) begin : g_sat
            localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};
            localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
            assign res = ovf ? (full[WIDTH] ? c_min : c_max) : full[WIDTH-1:0];
        end else begin : g_wrap
            assign res = full[WIDTH-1:0];
        end
    endgenerate

endmodule : alu_sat_addsub
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Two-stage valid/ready ALU: add, sub, pass and saturating accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter bit SATURATE = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_pipe_if.slave bus
);

    localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_s2_en;
    logic             w_s1_en;
    logic             w_accept;
    logic             w_acc_beat;
    logic             w_sub;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [WIDTH:0]   w_full;
    logic [WIDTH-1:0] w_s2_res;
    logic             w_s2_ovf;

    logic             r_s1_v;
    logic [WIDTH:0]   r_s1_full;
    logic             r_s1_ovf;
    alu_mode_e        r_s1_mode;
    logic             r_s2_v;
    logic [WIDTH-1:0] r_s2_res;
    logic             r_s2_ovf;
    logic [WIDTH-1:0] r_acc;

    assign w_s2_en    = !r_s2_v || bus.out_ready;
    assign w_s1_en    = !r_s1_v || w_s2_en;
    assign w_accept   = bus.in_valid && w_s1_en;
    assign w_acc_beat = w_accept && (bus.mode == ALU_ACC);

    // A clear in the same cycle as an ACC beat makes that beat start from zero.
    always_comb begin
        w_b   = bus.var_2;
        w_sub = 1'b0;
        case (bus.mode)
            ALU_SUB:  w_sub = 1'b1;
            ALU_PASS: w_b   = '0;
            ALU_ACC:  w_b   = bus.acc_clr ? '0 : r_acc;
            default:  w_b   = bus.var_2;
        endcase
    end

    alu_sat_addsub #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_addsub (
        .a    (bus.var_1),
        .b    (w_b),
        .sub  (w_sub),
        .res  (w_res),
        .ovf  (w_ovf),
        .full (w_full)
    );

    assign w_s2_ovf = r_s1_ovf && (r_s1_mode != ALU_PASS);
    assign w_s2_res = (SATURATE && w_s2_ovf) ? (r_s1_full[WIDTH] ? c_min : c_max)
                                             : r_s1_full[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_full <= '0;
            r_s1_ovf  <= 1'b0;
            r_s1_mode <= ALU_ADD;
            r_s2_v    <= 1'b0;
            r_s2_res  <= '0;
            r_s2_ovf  <= 1'b0;
            r_acc     <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_v <= w_accept;
                if (w_accept) begin
                    r_s1_full <= w_full;
                    r_s1_ovf  <= w_ovf;
                    r_s1_mode <= bus.mode;
                end
            end
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_res <= w_s2_res;
                    r_s2_ovf <= w_s2_ovf;
                end
            end
            // Updating at acceptance lets back-to-back ACC beats chain with no stall.
            if (w_acc_beat) begin
                r_acc <= w_res;
            end else if (bus.acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    assign bus.in_ready  = w_s1_en;
    assign bus.out_valid = r_s2_v;
    assign bus.result    = r_s2_res;
    assign bus.overflow  = r_s2_ovf;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Self-checking bench: queue-based reference model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(5))  m_if ();
    alu_pipe_if #(.WIDTH(5))  w_if ();
    alu_pipe_if #(.WIDTH(16)) h_if ();

    alu_pipe #(.WIDTH(5),  .SATURATE(1'b1)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
    alu_pipe #(.WIDTH(5),  .SATURATE(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(w_if.slave));
    alu_pipe #(.WIDTH(16), .SATURATE(1'b1)) u_wide (.clk(clk), .rst_n(rst_n), .bus(h_if.slave));

    typedef struct {
        int res;
        bit ovf;
        int cyc;
        bit has_lit;
        int lit_res;
        bit lit_ovf;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    int   acc_m   = 0;
    bit   prev_stall = 1'b0;
    int   prev_res   = 0;
    bit   prev_ovf   = 1'b0;
    bit   last_acc   = 1'b0;
    bit   stall_seen = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // True mathematical result, then clamp or fold into the WIDTH-bit range.
    function automatic void mdl(input int a, input int b, input bit sub, input int w,
                                input bit sat, output int r, output bit o);
        int t, mx, mn;
        t  = sub ? a - b : a + b;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        o  = (t > mx) || (t < mn);
        r  = t;
        if (o) begin
            if (sat) r = (t > mx) ? mx : mn;
            else     r = (t > mx) ? t - (1 << w) : t + (1 << w);
        end
    endfunction

    // One main-DUT cycle: drive after negedge, check, then advance the model.
    task automatic cyc(input bit v, input int m, input int a, input int b, input bit clr,
                       input bit ordy, input bit hl = 1'b0, input int lr = 0, input bit lo = 1'b0);
        bit   erdy, eov, o;
        int   r, got;
        exp_t e;
        @(negedge clk);
        m_if.in_valid  = v;
        m_if.mode      = alu_mode_e'(2'(m));
        m_if.var_1     = 5'(a);
        m_if.var_2     = 5'(b);
        m_if.acc_clr   = clr;
        m_if.out_ready = ordy;
        #1;
        cycle++;
        erdy = ordy || (q.size() < 2);
        eov  = (q.size() > 0) && (cycle - q[0].cyc >= 2);
        got  = $signed(m_if.result);
        chk("in_ready", int'(m_if.in_ready), int'(erdy));
        chk("out_valid", int'(m_if.out_valid), int'(eov));
        if (!m_if.in_ready) stall_seen = 1'b1;
        if (prev_stall) begin
            chk("hold_result", got, prev_res);
            chk("hold_overflow", int'(m_if.overflow), int'(prev_ovf));
        end
        if (eov && m_if.out_valid) begin
            chk("result", got, q[0].res);
            chk("overflow", int'(m_if.overflow), int'(q[0].ovf));
            if (q[0].has_lit) begin
                chk("lit_result", got, q[0].lit_res);
                chk("lit_overflow", int'(m_if.overflow), int'(q[0].lit_ovf));
            end
        end
        prev_stall = eov && !ordy;
        prev_res   = got;
        prev_ovf   = m_if.overflow;
        if (eov && ordy) void'(q.pop_front());
        last_acc = v && erdy;
        if (last_acc) begin
            case (m)
                0:       mdl(a, b, 1'b0, 5, 1'b1, r, o);
                3:       mdl(a, b, 1'b1, 5, 1'b1, r, o);
                1:       begin r = a; o = 1'b0; end
                default: begin mdl(a, clr ? 0 : acc_m, 1'b0, 5, 1'b1, r, o); acc_m = r; end
            endcase
            e = '{res: r, ovf: o, cyc: cycle, has_lit: hl, lit_res: lr, lit_ovf: lo};
            q.push_back(e);
        end
        if (clr && !(last_acc && m == 2)) acc_m = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    // SATURATE=0 and WIDTH=16 instances, driven in lock-step.
    task automatic side_tests();
        @(negedge clk);
        w_if.in_valid = 1'b1; w_if.mode = ALU_ADD; w_if.var_1 = 5'(15);  w_if.var_2 = 5'(1);
        h_if.in_valid = 1'b1; h_if.mode = ALU_ADD; h_if.var_1 = 16'(32767); h_if.var_2 = 16'(1);
        @(negedge clk);
        w_if.mode = ALU_SUB; w_if.var_1 = 5'(-16);    w_if.var_2 = 5'(1);
        h_if.mode = ALU_SUB; h_if.var_1 = 16'(-32768); h_if.var_2 = 16'(-1);
        #1;
        chk("wrap_early_valid", int'(w_if.out_valid), 0);
        @(negedge clk);
        w_if.in_valid = 1'b0; h_if.in_valid = 1'b0;
        #1;
        chk("wrap_add_valid", int'(w_if.out_valid), 1);
        chk("wrap_add_res", int'($signed(w_if.result)), -16);
        chk("wrap_add_ovf", int'(w_if.overflow), 1);
        chk("w16_add_res", int'($signed(h_if.result)), 32767);
        chk("w16_add_ovf", int'(h_if.overflow), 1);
        @(negedge clk);
        #1;
        chk("wrap_sub_res", int'($signed(w_if.result)), 15);
        chk("wrap_sub_ovf", int'(w_if.overflow), 1);
        chk("w16_sub_valid", int'(h_if.out_valid), 1);
        chk("w16_sub_res", int'($signed(h_if.result)), -32767);
        chk("w16_sub_ovf", int'(h_if.overflow), 0);
    endtask

    initial begin
        int r;
        bit o;
        int sent;
        m_if.in_valid = 1'b0; m_if.mode = ALU_ADD; m_if.var_1 = '0; m_if.var_2 = '0;
        m_if.acc_clr = 1'b0; m_if.out_ready = 1'b1;
        w_if.in_valid = 1'b0; w_if.mode = ALU_ADD; w_if.var_1 = '0; w_if.var_2 = '0;
        w_if.acc_clr = 1'b0; w_if.out_ready = 1'b1;
        h_if.in_valid = 1'b0; h_if.mode = ALU_ADD; h_if.var_1 = '0; h_if.var_2 = '0;
        h_if.acc_clr = 1'b0; h_if.out_ready = 1'b1;

        mdl(15, 1, 1'b0, 5, 1'b1, r, o);       chk("pin_sat_add", r, 15);  chk("pin_sat_add_o", int'(o), 1);
        mdl(15, 1, 1'b0, 5, 1'b0, r, o);       chk("pin_wrap_add", r, -16);
        mdl(-16, 1, 1'b1, 5, 1'b0, r, o);      chk("pin_wrap_sub", r, 15); chk("pin_wrap_sub_o", int'(o), 1);
        mdl(-3, 4, 1'b1, 5, 1'b1, r, o);       chk("pin_sub", r, -7);      chk("pin_sub_o", int'(o), 0);
        mdl(-32768, -1, 1'b1, 16, 1'b1, r, o); chk("pin_w16_sub", r, -32767);

        #1;
        chk("rst_out_valid", int'(m_if.out_valid), 0);
        chk("rst_in_ready", int'(m_if.in_ready), 1);
        chk("rst_result", int'(m_if.result), 0);
        chk("rst_overflow", int'(m_if.overflow), 0);
        #11 rst_n = 1'b1;

        side_tests();

        cyc(1'b1, 0, 7, 1, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        cyc(1'b1, 3, -3, 4, 1'b0, 1'b1, 1'b1, -7, 1'b0);
        cyc(1'b1, 1, -9, 5, 1'b0, 1'b1, 1'b1, -9, 1'b0);
        cyc(1'b1, 0, 15, 1, 1'b0, 1'b1, 1'b1, 15, 1'b1);
        cyc(1'b1, 3, -16, 1, 1'b0, 1'b1, 1'b1, -16, 1'b1);
        idle(3);

        cyc(1'b1, 2, 5, 0, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        cyc(1'b1, 2, 5, 0, 1'b0, 1'b1, 1'b1, 10, 1'b0);
        cyc(1'b1, 2, 5, 0, 1'b0, 1'b1, 1'b1, 15, 1'b0);
        cyc(1'b1, 2, 5, 0, 1'b0, 1'b1, 1'b1, 15, 1'b1);
        cyc(1'b1, 2, -3, 0, 1'b1, 1'b1, 1'b1, -3, 1'b0);
        idle(3);

        sent = 0;
        stall_seen = 1'b0;
        for (int t = 0; t < 40 && (sent < 6 || q.size() > 0); t++) begin
            cyc(sent < 6, 0, sent, sent + 1, 1'b0, !(t >= 3 && t <= 5), 1'b1, 2 * sent + 1, 1'b0);
            if (last_acc) sent++;
        end
        chk("bp_all_sent", sent, 6);
        chk("bp_drained", q.size(), 0);
        chk("bp_stall_seen", int'(stall_seen), 1);

        cyc(1'b1, 0, 1, 1, 1'b0, 1'b1);
        cyc(1'b1, 0, 3, 3, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        m_if.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(m_if.out_valid), 0);
        chk("midrst_result", int'(m_if.result), 0);
        chk("midrst_in_ready", int'(m_if.in_ready), 1);
        q.delete();
        acc_m = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(4);
        cyc(1'b1, 0, 2, 2, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        cyc(1'b1, 2, 3, 0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(9) < 7, int'($urandom_range(3)),
                int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                $urandom_range(9) == 0, $urandom_range(9) < 7);
        end
        idle(6);
        chk("final_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_pipe
`default_nettype wire
